// File: rtl/biu_pkg.sv
// Shared types and constants for the bus interface unit.
package biu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        DATA    = 2'd2,
        RECOVER = 2'd3
    } biu_state_t;

    localparam int WAIT_CNT_W = 4;

    // Bus strobe levels while no cycle is in progress
    localparam logic ALE_OFF  = 1'b0;
    localparam logic N_ME_OFF = 1'b1;
    localparam logic N_OE_OFF = 1'b1;
    localparam logic RN_W_OFF = 1'b1;
    localparam logic ENB_OFF  = 1'b0;

    function automatic int tmo_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/biu_wait_timer.sv
// Data-phase wait-state down-counter and optional nWait timeout up-counter.
// The timeout counter exists only when BIU_TIMEOUT_EN is defined.
module biu_wait_timer
    import biu_pkg::*;
#(
    parameter int WAIT_MIN = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_active,
    input  logic i_n_wait,
    output logic o_done,
    output logic o_timed_out
);

    logic [WAIT_CNT_W-1:0] r_wait_cnt;

    // Minimum wait states: loaded in the address phase, counted down in data
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wait_cnt <= '0;
        end else if (i_load) begin
            r_wait_cnt <= WAIT_CNT_W'(WAIT_MIN);
        end else if (i_active && (r_wait_cnt != '0)) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
        end
    end

    assign o_done = i_active && (r_wait_cnt == '0) && i_n_wait;

`ifdef BIU_TIMEOUT_EN
    localparam int TMO_W = tmo_cnt_w(TIMEOUT);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic [TMO_W-1:0] w_tmo_inc;

    assign w_tmo_inc = (r_tmo_cnt == TMO_W'(TIMEOUT)) ? r_tmo_cnt : r_tmo_cnt + 1'b1;

    // Consecutive nWait-low cycles, saturating at TIMEOUT
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tmo_cnt <= '0;
        end else if (i_load) begin
            r_tmo_cnt <= '0;
        end else if (i_active) begin
            r_tmo_cnt <= i_n_wait ? '0 : w_tmo_inc;
        end
    end

    // The edge on which the count reaches TIMEOUT ends the data phase
    assign o_timed_out = i_active && !i_n_wait && (w_tmo_inc == TMO_W'(TIMEOUT));
`else
    assign o_timed_out = 1'b0;
`endif

endmodule

// File: rtl/bus_interface_unit.sv
// Multiplexed address/data bus controller with request/response handshake.
// Optional nWait timeout with error response: define BIU_TIMEOUT_EN.
module bus_interface_unit
    import biu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int WAIT_MIN = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [DATA_W-1:0] o_data_out,
    input  logic [DATA_W-1:0] i_data_in,
    output logic              o_ale,
    output logic              o_n_me,
    output logic              o_n_oe,
    output logic              o_rn_w,
    output logic              o_enb,
    input  logic              i_n_wait
);

    biu_state_t        r_state;
    biu_state_t        w_nxt_state;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic              w_done;
    logic              w_timed_out;
    logic              w_ale, w_n_me, w_n_oe, w_rn_w, w_enb;
    logic [DATA_W-1:0] w_dout;

    biu_wait_timer #(
        .WAIT_MIN (WAIT_MIN),
        .TIMEOUT  (TIMEOUT)
    ) u_wait_timer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (r_state == ADDR),
        .i_active    (r_state == DATA),
        .i_n_wait    (i_n_wait),
        .o_done      (w_done),
        .o_timed_out (w_timed_out)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            IDLE:    if (i_req_valid) w_nxt_state = ADDR; else w_nxt_state = IDLE;
            ADDR:    w_nxt_state = DATA;
            DATA:    if (w_done || w_timed_out) w_nxt_state = RECOVER; else w_nxt_state = DATA;
            RECOVER: w_nxt_state = IDLE;
            default: w_nxt_state = IDLE;
        endcase
    end

    // Strobes are decoded from the upcoming state so they register cleanly;
    // ADDR is only entered from IDLE, so the live request feeds its outputs
    always_comb begin
        w_ale  = ALE_OFF;
        w_n_me = N_ME_OFF;
        w_n_oe = N_OE_OFF;
        w_rn_w = RN_W_OFF;
        w_enb  = ENB_OFF;
        w_dout = '0;
        case (w_nxt_state)
            ADDR: begin
                w_ale  = 1'b1;
                w_enb  = 1'b1;
                w_rn_w = ~i_req_write;
                w_dout = DATA_W'(i_req_addr);
            end
            DATA: begin
                w_n_me = 1'b0;
                w_rn_w = ~r_write;
                w_n_oe = r_write;
                w_enb  = r_write;
                w_dout = r_write ? r_wdata : '0;
            end
            default: begin
                w_dout = '0;
            end
        endcase
    end

    // Request latch, taken only when accepted in IDLE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_write <= 1'b0;
            r_wdata <= '0;
        end else if ((r_state == IDLE) && i_req_valid) begin
            r_write <= i_req_write;
            r_wdata <= i_req_wdata;
        end
    end

    // Registered bus strobes and response
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ale       <= ALE_OFF;
            o_n_me      <= N_ME_OFF;
            o_n_oe      <= N_OE_OFF;
            o_rn_w      <= RN_W_OFF;
            o_enb       <= ENB_OFF;
            o_data_out  <= '0;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= '0;
        end else begin
            o_ale       <= w_ale;
            o_n_me      <= w_n_me;
            o_n_oe      <= w_n_oe;
            o_rn_w      <= w_rn_w;
            o_enb       <= w_enb;
            o_data_out  <= w_dout;
            o_req_ready <= (w_nxt_state == IDLE);
            o_rsp_valid <= (w_nxt_state == RECOVER);
            o_rsp_err   <= (w_nxt_state == RECOVER) && w_timed_out;
            if ((r_state == DATA) && w_done && !r_write) begin
                o_rsp_rdata <= i_data_in;
            end
        end
    end

endmodule

// File: tb/tb_bus_interface_unit.sv
// Directed bench for bus_interface_unit: three instances cover WAIT_MIN 0/2 and a 32/24-bit build.
module tb_bus_interface_unit;

    // Strobe vector order: {ALE, nME, nOE, RnW, ENB, ReqReady, RspValid, RspErr}
    localparam logic [7:0] S_IDLE    = 8'b0111_0100;
    localparam logic [7:0] S_ADDR_RD = 8'b1111_1000;
    localparam logic [7:0] S_DATA_RD = 8'b0001_0000;
    localparam logic [7:0] S_REC     = 8'b0111_0010;
    localparam logic [7:0] S_ADDR_WR = 8'b1110_1000;
    localparam logic [7:0] S_DATA_WR = 8'b0010_1000;
    localparam logic [7:0] S_REC_ERR = 8'b0111_0011;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, n_wait;
    logic [23:0] req_addr;
    logic [31:0] req_wdata, data_in;

    logic        rdy0, rv0, er0, ale0, nme0, noe0, rnw0, enb0;
    logic [15:0] rd0, do0;
    logic        rdy2, rv2, er2, ale2, nme2, noe2, rnw2, enb2;
    logic [15:0] rd2, do2;
    logic        rdy32, rv32, er32, ale32, nme32, noe32, rnw32, enb32;
    logic [31:0] rd32, do32;
    logic [7:0]  st0, st2, st32;

    int n_total = 0;
    int n_bad   = 0;

    assign st0  = {ale0, nme0, noe0, rnw0, enb0, rdy0, rv0, er0};
    assign st2  = {ale2, nme2, noe2, rnw2, enb2, rdy2, rv2, er2};
    assign st32 = {ale32, nme32, noe32, rnw32, enb32, rdy32, rv32, er32};

    always #5 clk = ~clk;

    bus_interface_unit #(.DATA_W(16), .ADDR_W(16), .WAIT_MIN(0), .TIMEOUT(15)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(rdy0),
        .i_req_write(req_write), .i_req_addr(req_addr[15:0]), .i_req_wdata(req_wdata[15:0]),
        .o_rsp_valid(rv0), .o_rsp_rdata(rd0), .o_rsp_err(er0), .o_data_out(do0),
        .i_data_in(data_in[15:0]), .o_ale(ale0), .o_n_me(nme0), .o_n_oe(noe0),
        .o_rn_w(rnw0), .o_enb(enb0), .i_n_wait(n_wait));

    bus_interface_unit #(.DATA_W(16), .ADDR_W(16), .WAIT_MIN(2), .TIMEOUT(15)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(rdy2),
        .i_req_write(req_write), .i_req_addr(req_addr[15:0]), .i_req_wdata(req_wdata[15:0]),
        .o_rsp_valid(rv2), .o_rsp_rdata(rd2), .o_rsp_err(er2), .o_data_out(do2),
        .i_data_in(data_in[15:0]), .o_ale(ale2), .o_n_me(nme2), .o_n_oe(noe2),
        .o_rn_w(rnw2), .o_enb(enb2), .i_n_wait(n_wait));

    bus_interface_unit #(.DATA_W(32), .ADDR_W(24), .WAIT_MIN(0), .TIMEOUT(15)) u_dut32 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(rdy32),
        .i_req_write(req_write), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rv32), .o_rsp_rdata(rd32), .o_rsp_err(er32), .o_data_out(do32),
        .i_data_in(data_in), .o_ale(ale32), .o_n_me(nme32), .o_n_oe(noe32),
        .o_rn_w(rnw32), .o_enb(enb32), .i_n_wait(n_wait));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(rdy0 && rdy2 && rdy32) && n < 40) begin
            tick();
            n++;
        end
        check("idle_wait", {31'd0, rdy0 && rdy2 && rdy32}, 32'd1);
    endtask

    logic [7:0] b2b_exp [8];

    initial begin
        b2b_exp = '{S_ADDR_RD, S_DATA_RD, S_REC, S_IDLE, S_ADDR_RD, S_DATA_RD, S_REC, S_IDLE};
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; n_wait = 1'b1;
        req_addr = 24'h0; req_wdata = 32'h0; data_in = 32'h0;
        #3;
        check("rst_strobes", {24'd0, st0}, {24'd0, S_IDLE});
        check("rst_dout", {16'd0, do0}, 32'h0);
        check("rst_rdata", {16'd0, rd0}, 32'h0);
        @(posedge clk); #1; rst = 1'b0;
        tick();

        // Read, no waits
        req_addr = 24'h001234; req_write = 1'b0; req_valid = 1'b1; data_in = 32'h0000BEEF;
        tick();
        check("rd_addr_st", {24'd0, st0}, {24'd0, S_ADDR_RD});
        check("rd_addr_dout", {16'd0, do0}, 32'h1234);
        req_valid = 1'b0;
        tick();
        check("rd_data_st", {24'd0, st0}, {24'd0, S_DATA_RD});
        tick();
        check("rd_rec_st", {24'd0, st0}, {24'd0, S_REC});
        check("rd_rdata", {16'd0, rd0}, 32'hBEEF);
        tick();
        check("rd_idle_st", {24'd0, st0}, {24'd0, S_IDLE});
        wait_idle();

        // Write with WAIT_MIN=2; later request changes must not leak in
        req_addr = 24'h000040; req_wdata = 32'h000000FF; req_write = 1'b1; req_valid = 1'b1;
        tick();
        check("wr_addr_st", {24'd0, st2}, {24'd0, S_ADDR_WR});
        check("wr_addr_dout", {16'd0, do2}, 32'h0040);
        req_valid = 1'b0; req_wdata = 32'h00001111; req_addr = 24'h000999;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("wr_data_st%0d", i), {24'd0, st2}, {24'd0, S_DATA_WR});
            check($sformatf("wr_data_dout%0d", i), {16'd0, do2}, 32'h00FF);
        end
        tick();
        check("wr_rec_st", {24'd0, st2}, {24'd0, S_REC});
        tick();
        check("wr_ready_back", {24'd0, st2}, {24'd0, S_IDLE});
        wait_idle();

        // Read held by nWait for 4 data cycles
        req_addr = 24'h000ABC; req_write = 1'b0; req_valid = 1'b1;
        tick();
        check("nw_addr_st", {24'd0, st0}, {24'd0, S_ADDR_RD});
        req_valid = 1'b0; n_wait = 1'b0; data_in = 32'h00001111;
        tick();
        check("nw_data_st0", {24'd0, st0}, {24'd0, S_DATA_RD});
        for (int i = 1; i < 5; i++) begin
            tick();
            check($sformatf("nw_data_st%0d", i), {24'd0, st0}, {24'd0, S_DATA_RD});
        end
        n_wait = 1'b1; data_in = 32'h0000C0DE;
        tick();
        check("nw_rec_st", {24'd0, st0}, {24'd0, S_REC});
        check("nw_rdata", {16'd0, rd0}, 32'hC0DE);
        wait_idle();

        // nWait stuck low
        req_addr = 24'h000055; req_write = 1'b0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; n_wait = 1'b0; data_in = 32'h00004D4D;
`ifdef BIU_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("to_data_st%0d", i), {24'd0, st0}, {24'd0, S_DATA_RD});
        end
        tick();
        check("to_rec_err", {24'd0, st0}, {24'd0, S_REC_ERR});
        check("to_rdata_kept", {16'd0, rd0}, 32'hC0DE);
        n_wait = 1'b1;
`else
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check("hold_data_st", {24'd0, st0}, {24'd0, S_DATA_RD});
        n_wait = 1'b1;
        tick();
        check("hold_rec_noerr", {24'd0, st0}, {24'd0, S_REC});
        check("hold_rdata", {16'd0, rd0}, 32'h4D4D);
`endif
        wait_idle();

        // Reset during the data phase of a write
        req_addr = 24'h000077; req_wdata = 32'h0000A5A5; req_write = 1'b1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; n_wait = 1'b0;
        tick();
        check("mr_data_st", {24'd0, st0}, {24'd0, S_DATA_WR});
        #2; rst = 1'b1;
        #1;
        check("mr_async_st", {24'd0, st0}, {24'd0, S_IDLE});
        check("mr_async_dout", {16'd0, do0}, 32'h0);
        @(posedge clk); #1; rst = 1'b0; n_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mr_after_st%0d", i), {24'd0, st0}, {24'd0, S_IDLE});
        end

        // Back-to-back reads, ReqValid held
        req_addr = 24'h9ACDEF; req_write = 1'b0; req_valid = 1'b1; data_in = 32'h13579BDF;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("b2b_st0_%0d", i), {24'd0, st0}, {24'd0, b2b_exp[i]});
            check($sformatf("b2b_st32_%0d", i), {24'd0, st32}, {24'd0, b2b_exp[i]});
            if ((i % 4) == 0) begin
                check($sformatf("b2b_dout0_%0d", i), {16'd0, do0}, 32'hCDEF);
                check($sformatf("b2b_dout32_%0d", i), do32, 32'h009ACDEF);
            end
            if ((i % 4) == 2) begin
                check($sformatf("b2b_rd0_%0d", i), {16'd0, rd0}, 32'h9BDF);
                check($sformatf("b2b_rd32_%0d", i), rd32, 32'h13579BDF);
            end
        end
        req_valid = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_interface_unit.md
# bus_interface_unit

Parametrised external-memory bus controller sitting between the CPU core's control/datapath and the multiplexed address/data system bus. It generalises the core's fixed 16-bit ALE/nME/nOE/RnW/ENB/nWait handling into a width-configurable, request/response-handshaked unit. It adds programmable minimum wait states, a turnaround cycle and an optional nWait timeout with error response.

## Interface
- DATA_W, 16: system bus / data width; must satisfy ADDR_W <= DATA_W.
- ADDR_W, 16: address width; zero-extended onto the bus during the address phase.
- WAIT_MIN, 0: minimum data-phase wait states inserted regardless of nWait (0..15).
- TIMEOUT, 15: maximum consecutive cycles nWait may hold a data phase before error termination (1..255).
- Clock  in  1  single system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ReqValid  in  1  core requests a bus cycle.
- ReqReady  out  1  unit accepts request this cycle.
- ReqWrite  in  1  1 = write, 0 = read.
- ReqAddr  in  ADDR_W  cycle address.
- ReqWData  in  DATA_W  write data.
- RspValid  out  1  one-cycle pulse: cycle complete.
- RspRData  out  DATA_W  read data, held until next RspValid.
- RspErr  out  1  qualified by RspValid: cycle ended by timeout.
- Data_out  out  DATA_W  multiplexed address/data driven to the bus.
- Data_in  in  DATA_W  bus read data.
- ALE  out  1  address latch enable, high in address phase.
- nME  out  1  memory enable, active low in data phase.
- nOE  out  1  output enable, low in read data phase.
- RnW  out  1  1 = read, 0 = write.
- ENB  out  1  bus drive enable for Data_out.
- nWait  in  1  active-low wait from memory.

## Operation
- States (biu_state_t): IDLE, ADDR, DATA, RECOVER.
- IDLE: ReqReady=1. On ReqValid, latch ReqWrite/ReqAddr/ReqWData and go to ADDR. Otherwise stay.
- ADDR, exactly 1 cycle:
  - ALE=1, ENB=1, Data_out=zero-extended address, nME=1, nOE=1.
  - RnW=~write.
  - Load wait counter with WAIT_MIN and clear timeout counter.
  - Go to DATA.
- DATA:
  - nME=0, RnW=~write, nOE=write, ENB=write, Data_out=write ? wdata : 0.
  - The cycle completes at the first clock edge where wait counter==0 and nWait==1.
  - The wait counter decrements each DATA cycle while nonzero.
  - The timeout counter increments each DATA cycle in which nWait==0 and resets to 0 when nWait==1.
- Completion:
  - Read cycles capture Data_in into RspRData on the completing edge.
  - Go to RECOVER.
- RECOVER, exactly 1 cycle:
  - All strobes inactive (ALE=0, nME=1, nOE=1, RnW=1, ENB=0, Data_out=0).
  - RspValid=1; RspErr per outcome.
  - Go to IDLE. Guarantees bus turnaround between back-to-back cycles.
- Outputs are registered from state. No combinational path from nWait or ReqValid to bus strobes.

## Timing
- Reset values: state IDLE, ALE=0, nME=1, nOE=1, RnW=1, ENB=0, Data_out=0, ReqReady=1, RspValid=0, RspErr=0, RspRData=0, counters 0.
- Reset mid-cycle: all strobes return to inactive asynchronously. No RspValid is issued for the aborted cycle.
- Minimum latency, WAIT_MIN=0 with nWait high: request accepted at edge 0, ADDR cycle 1, DATA cycle 2, RspValid cycle 3, ReqReady again cycle 4. Bus cycle = 2 + WAIT_MIN + extra nWait cycles.
- nWait is sampled only in DATA and ignored in other states.
- When both the wait counter and nWait would hold the data phase, the longer of the two wins.
- ReqValid asserted while not in IDLE is ignored, and the request is not latched. The core holds ReqValid until it sees ReqReady.
- Timeout counter saturates at TIMEOUT. Equality terminates the cycle.

## Configuration
- BIU_TIMEOUT_EN defined:
  - When the timeout counter reaches TIMEOUT while nWait==0, DATA ends.
  - RECOVER then follows with RspErr=1.
  - RspRData is left unchanged on reads.
- BIU_TIMEOUT_EN undefined:
  - No timeout counter is synthesised.
  - DATA is held indefinitely while nWait==0.
  - RspErr is tied to 0 and the TIMEOUT parameter is ignored.

## Structure
- Package biu_pkg holds:
  - the biu_state_t enum;
  - localparam widths for the wait counter (4 bits) and timeout counter ($clog2(TIMEOUT+1));
  - the inactive strobe defaults as constants.
- One sub-module, biu_wait_timer, holds the wait-state down-counter and the timeout up-counter. Its outputs are Done and TimedOut. Its inputs are Load, Active and nWait.
- The top level contains the FSM, request/data latches and output registers.

## Test plan
- Read, WAIT_MIN=0, nWait=1, addr 0x1234, Data_in=0xBEEF:
  - ALE high one cycle with Data_out=0x1234, then nME=0/nOE=0 one cycle.
  - RspValid at cycle 3 with RspRData=0xBEEF and RspErr=0.
- Write, WAIT_MIN=2, addr 0x0040, data 0x00FF:
  - DATA lasts 3 cycles with ENB=1, RnW=0, nOE=1 and Data_out=0x00FF.
  - RspValid follows, and ReqReady returns the cycle after.
- Read, WAIT_MIN=0, nWait held low 4 DATA cycles: DATA lasts 5 cycles and captures Data_in on the edge nWait rises.
- BIU_TIMEOUT_EN, TIMEOUT=15, nWait stuck low: DATA ends after 15 cycles, RspValid=1 with RspErr=1, and RspRData is unchanged.
- Reset asserted during DATA of a write:
  - nME=1, ENB=0, ALE=0 immediately without waiting for a clock.
  - State returns to IDLE with no RspValid, and ReqReady=1 after release.
- Back-to-back reads with ReqValid held high: each pair of DATA phases is separated by RECOVER and IDLE cycles with all strobes inactive. Also run with DATA_W=32, ADDR_W=24, where the address appears zero-extended on Data_out.
